// File: rtl/spi_periferico_esclavo.sv
// -----------------------------------------------------------------------------
// spi_periferico_esclavo
//
// SPI mode-0 responder. The master's SCLK, MOSI and CS_n are oversampled in
// the clk_fpga domain, MSB-first frames are deserialised into rx_data_o with
// a pending/overrun handshake, and a locally loaded transmit byte is shifted
// out on MISO.
//
// Ports:
//   clk_fpga, rst_n         system clock, asynchronous active-low reset
//   i_SPI_Clk/MOSI/CS_n     SPI pins from the master (mode 0, CS active low)
//   o_SPI_MISO              slave data out, MSB first, 0 while not selected
//   tx_data_i, tx_load_i    byte to return and its capture strobe
//   rx_ack_i                clears rx_pending_o
//   clr_i                   clears overrun_o and abort_o
//   rx_data_o, rx_valid_o   last complete frame and its one-cycle update pulse
//   rx_pending_o            frame received and not yet acknowledged
//   overrun_o, abort_o      sticky error flags
//   busy_o                  frame engine not idle
//   frame_cnt_o             completed frame count, wraps at 256
// -----------------------------------------------------------------------------
module spi_periferico_esclavo #(
  parameter int N    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk_fpga,
  input  logic         rst_n,
  input  logic         i_SPI_Clk,
  input  logic         i_SPI_MOSI,
  input  logic         i_CS_n,
  output logic         o_SPI_MISO,
  input  logic [N-1:0] tx_data_i,
  input  logic         tx_load_i,
  input  logic         rx_ack_i,
  input  logic         clr_i,
  output logic [N-1:0] rx_data_o,
  output logic         rx_valid_o,
  output logic         rx_pending_o,
  output logic         overrun_o,
  output logic         abort_o,
  output logic         busy_o,
  output logic [7:0]   frame_cnt_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [CW-1:0] ONE_BIT  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [SYNC-1:0] r_sclk_sync;
  logic [SYNC-1:0] r_mosi_sync;
  logic [SYNC-1:0] r_cs_sync;
  logic            r_sclk_hist;
  logic            r_cs_hist;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_cs_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_busy;
  logic [CW-1:0] r_bit_cnt;
  logic [N-1:0]  r_tx_buf;
  logic [N-1:0]  r_tx_shift;
  logic [N-1:0]  r_rx_shift;
  logic [N-1:0]  r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_pending;
  logic          r_overrun;
  logic          r_abort;
  logic [7:0]    r_frame_cnt;

  logic w_done;
  logic w_overrun_set;
  logic w_abort_set;

  // Synchroniser chains plus one history flop for SCLK and CS edge detection.
  // CS idles high, so its chain resets to 1 to avoid a false fall after reset.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC-2:0], i_SPI_Clk};
      r_mosi_sync <= {r_mosi_sync[SYNC-2:0], i_SPI_MOSI};
      r_cs_sync   <= {r_cs_sync[SYNC-2:0], i_CS_n};
      r_sclk_hist <= r_sclk_sync[SYNC-1];
      r_cs_hist   <= r_cs_sync[SYNC-1];
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC-1];
  assign w_mosi_s    = r_mosi_sync[SYNC-1];
  assign w_cs_s      = r_cs_sync[SYNC-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
  assign w_cs_rise   = w_cs_s & ~r_cs_hist;
  assign w_cs_fall   = ~w_cs_s & r_cs_hist;

  // Next-state decode for the frame engine.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_state_nxt = ST_SHIFT;
        else           w_state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        if (w_cs_rise)                                w_state_nxt = ST_IDLE;
        else if (w_sclk_rise && r_bit_cnt == LAST_BIT) w_state_nxt = ST_DONE;
        else                                          w_state_nxt = ST_SHIFT;
      end
      ST_DONE: begin
        if (w_cs_s) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_SHIFT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Shift datapath. tx_shift is kept at 0 whenever the engine is idle so that
  // MISO can be driven straight from its MSB and stays low while deselected.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf   <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (tx_load_i) r_tx_buf <= tx_data_i;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_tx_shift <= r_tx_buf;
            // A rise seen together with the CS fall is the first data bit.
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[N-2:0], w_mosi_s};
              r_bit_cnt  <= ONE_BIT;
            end else begin
              r_bit_cnt  <= '0;
            end
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_tx_shift <= '0;
            r_bit_cnt  <= '0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[N-2:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + ONE_BIT;
          end else if (w_sclk_fall && r_bit_cnt != '0) begin
            // The fall that trails the last bit of the previous frame arrives
            // with bit_cnt already cleared and must not disturb the reload.
            r_tx_shift <= {r_tx_shift[N-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          r_tx_shift <= w_cs_s ? '0 : r_tx_buf;
          r_bit_cnt  <= '0;
        end
        default: begin
          r_tx_shift <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign w_done        = (r_state == ST_DONE);
  assign w_overrun_set = w_done & r_rx_pending & ~rx_ack_i;
  assign w_abort_set   = (r_state == ST_SHIFT) & w_cs_rise & (r_bit_cnt != '0);

  // Receive result, handshake and sticky error flags. A new event outranks
  // clr_i, and a completing frame outranks rx_ack_i.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_pending <= 1'b0;
      r_overrun    <= 1'b0;
      r_abort      <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_rx_valid <= w_done;
      if (w_done) begin
        r_rx_data   <= r_rx_shift;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_done)        r_rx_pending <= 1'b1;
      else if (rx_ack_i) r_rx_pending <= 1'b0;
      if (w_overrun_set) r_overrun <= 1'b1;
      else if (clr_i)    r_overrun <= 1'b0;
      if (w_abort_set)   r_abort <= 1'b1;
      else if (clr_i)    r_abort <= 1'b0;
    end
  end

  assign o_SPI_MISO   = r_tx_shift[N-1];
  assign rx_data_o    = r_rx_data;
  assign rx_valid_o   = r_rx_valid;
  assign rx_pending_o = r_rx_pending;
  assign overrun_o    = r_overrun;
  assign abort_o      = r_abort;
  assign busy_o       = r_busy;
  assign frame_cnt_o  = r_frame_cnt;

endmodule
